// File: rtl/uarttx_fifo.sv
// 8N1-plus-parity UART transmitter with a small input FIFO.
// Frames are LSB first: start, 8 data, parity, stop; each bit lasts CLKS_PER_BIT clocks.
module uarttx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic        PARITY_MODE  = 1'b0,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] datain,
    input  logic       wrsig,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic       empty,
    output logic       txdone,
    output logic       overflow
);

    localparam int unsigned CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt_c;
    logic             wr_en_c;
    logic             pop_c;
    logic [7:0]       head_c;

    // Transmit FSM
    state_t           state;
    logic [CYC_W-1:0] cyc;
    logic [2:0]       idx;
    logic [7:0]       sh;
    logic             par;
    logic             cyc_last_c;
    logic             line_c;

    // full is the pre-pop view, so a write against a full FIFO is dropped even on a pop cycle
    assign wr_en_c    = wrsig && !full;
    assign head_c     = mem[rd_ptr];
    assign cyc_last_c = (cyc == CYC_LAST);
    assign pop_c      = !empty && ((state == IDLE) || ((state == STOP) && cyc_last_c));

    always_comb begin
        count_nxt_c = count + CNT_W'(wr_en_c) - CNT_W'(pop_c);
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr] <= datain;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (wr_en_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count    <= count_nxt_c;
            full     <= (count_nxt_c == CNT_FULL);
            empty    <= (count_nxt_c == '0);
            overflow <= wrsig && full;
        end
    end

    // Line level for the current state; registered into tx one cycle later
    always_comb begin
        line_c = 1'b1;
        case (state)
            IDLE:    line_c = 1'b1;
            START:   line_c = 1'b0;
            DATA:    line_c = sh[idx];
            PARITY:  line_c = par;
            STOP:    line_c = 1'b1;
            default: line_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cyc    <= '0;
            idx    <= '0;
            sh     <= '0;
            par    <= 1'b0;
            tx     <= 1'b1;
            busy   <= 1'b0;
            txdone <= 1'b0;
        end else begin
            tx     <= line_c;
            busy   <= (state != IDLE);
            txdone <= (state == STOP) && cyc_last_c;

            if (state != IDLE) begin
                cyc <= cyc_last_c ? '0 : cyc + CYC_W'(1);
            end

            case (state)
                IDLE: begin
                    cyc <= '0;
                    if (pop_c) begin
                        sh    <= head_c;
                        par   <= PARITY_MODE ^ (^head_c);
                        state <= START;
                    end
                end
                START: begin
                    if (cyc_last_c) begin
                        idx   <= '0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (cyc_last_c) begin
                        if (idx == 3'd7) begin
                            state <= PARITY;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (cyc_last_c) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    // Chain straight into the next frame when a byte is waiting
                    if (cyc_last_c) begin
                        if (pop_c) begin
                            sh    <= head_c;
                            par   <= PARITY_MODE ^ (^head_c);
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uarttx_fifo.sv
// Directed bench for uarttx_fifo: even/odd parity vectors, burst/overflow, back-to-back frames, async reset.
module tb_uarttx_fifo;

    localparam int unsigned CPB   = 16;
    localparam int unsigned FRAME = 11 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] datain = 8'h00;
    logic       wrsig = 1'b0;
    logic       wrsig_o = 1'b0;

    logic tx, busy, full, empty, txdone, overflow;
    logic tx_o, busy_o, full_o, empty_o, txdone_o, overflow_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uarttx_fifo #(.CLKS_PER_BIT(CPB), .PARITY_MODE(1'b0), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .reset(reset), .datain(datain), .wrsig(wrsig),
        .tx(tx), .busy(busy), .full(full), .empty(empty),
        .txdone(txdone), .overflow(overflow)
    );

    uarttx_fifo #(.CLKS_PER_BIT(CPB), .PARITY_MODE(1'b1), .FIFO_DEPTH(4)) u_dut_odd (
        .clk(clk), .reset(reset), .datain(datain), .wrsig(wrsig_o),
        .tx(tx_o), .busy(busy_o), .full(full_o), .empty(empty_o),
        .txdone(txdone_o), .overflow(overflow_o)
    );

    typedef struct {
        logic [7:0] data;
        logic       par_e;
        logic       par_o;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic p);
        return {1'b1, p, d, 1'b0};
    endfunction

    // Entered with frame cycle 0 already sampled; leaves at frame cycle FRAME-1.
    task automatic check_frame(input string tag, input logic [10:0] exp_e,
                               input logic [10:0] exp_o, input bit use_o);
        int bad_e, bad_o, busy_cnt, done_at, done_cnt;
        bad_e = 0; bad_o = 0; busy_cnt = 0; done_at = -1; done_cnt = 0;
        for (int k = 0; k < int'(FRAME); k++) begin
            if (k > 0) tick();
            if (tx !== exp_e[k / int'(CPB)]) bad_e++;
            if (use_o && (tx_o !== exp_o[k / int'(CPB)])) bad_o++;
            if (busy === 1'b1) busy_cnt++;
            if (txdone === 1'b1) begin
                done_cnt++;
                done_at = k;
            end
        end
        check({tag, " tx_bad_cycles"}, 32'(bad_e), 32'd0);
        if (use_o) check({tag, " tx_odd_bad_cycles"}, 32'(bad_o), 32'd0);
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(FRAME));
        check({tag, " txdone_count"}, 32'(done_cnt), 32'd1);
        check({tag, " txdone_cycle"}, 32'(done_at), 32'(FRAME - 1));
    endtask

    initial begin
        int bad;
        vecs[0] = '{8'h55, 1'b0, 1'b1};
        vecs[1] = '{8'h01, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 1'b0, 1'b1};
        vecs[4] = '{8'hA3, 1'b0, 1'b1};
        vecs[5] = '{8'h3C, 1'b0, 1'b1};
        vecs[6] = '{8'h07, 1'b1, 1'b0};
        vecs[7] = '{8'h80, 1'b1, 1'b0};

        // Reset state
        tick();
        tick();
        check("rst tx", 32'(tx), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst full", 32'(full), 32'd0);
        check("rst empty", 32'(empty), 32'd1);
        check("rst txdone", 32'(txdone), 32'd0);
        check("rst overflow", 32'(overflow), 32'd0);
        reset = 1'b1;
        tick();
        tick();

        // Single frames on both parity modes, table driven
        foreach (vecs[i]) begin
            datain  = vecs[i].data;
            wrsig   = 1'b1;
            wrsig_o = 1'b1;
            tick();
            wrsig   = 1'b0;
            wrsig_o = 1'b0;
            datain  = ~vecs[i].data;
            check($sformatf("v%0d empty_after_write", i), 32'(empty), 32'd0);
            check($sformatf("v%0d overflow", i), 32'(overflow), 32'd0);
            tick();
            check($sformatf("v%0d tx_edge_n1", i), 32'(tx), 32'd1);
            tick();
            check($sformatf("v%0d tx_edge_n2", i), 32'(tx), 32'd0);
            check_frame($sformatf("v%0d", i), frame_bits(vecs[i].data, vecs[i].par_e),
                        frame_bits(vecs[i].data, vecs[i].par_o), 1'b1);
            tick();
            check($sformatf("v%0d busy_after", i), 32'(busy), 32'd0);
            check($sformatf("v%0d tx_after", i), 32'(tx), 32'd1);
            check($sformatf("v%0d empty_after", i), 32'(empty), 32'd1);
            tick();
            tick();
        end

        // Burst into a busy transmitter: fill, overflow, then write on the pop edge
        datain = 8'h11;
        wrsig  = 1'b1;
        tick();
        wrsig = 1'b0;
        tick();
        tick();
        check("burst prime tx_low", 32'(tx), 32'd0);
        wrsig = 1'b1;
        datain = 8'hC1; tick();
        datain = 8'h22; tick();
        datain = 8'h93; tick();
        check("burst full_after_3", 32'(full), 32'd0);
        datain = 8'h4E; tick();
        check("burst full_after_4", 32'(full), 32'd1);
        datain = 8'hEE; tick();
        check("burst overflow_5th", 32'(overflow), 32'd1);
        check("burst full_5th", 32'(full), 32'd1);
        wrsig = 1'b0;
        tick();
        check("burst overflow_clear", 32'(overflow), 32'd0);
        for (int c = 6; c < 174; c++) tick();
        datain = 8'h77;
        wrsig  = 1'b1;
        tick();
        wrsig = 1'b0;
        check("popwr txdone", 32'(txdone), 32'd1);
        check("popwr overflow", 32'(overflow), 32'd1);
        check("popwr full", 32'(full), 32'd0);
        check("popwr empty", 32'(empty), 32'd0);
        tick();
        check("b2b no_gap_tx", 32'(tx), 32'd0);
        check("b2b no_gap_busy", 32'(busy), 32'd1);
        check("b2b overflow_clear", 32'(overflow), 32'd0);
        check("b2b f0 empty", 32'(empty), 32'd0);
        check_frame("b2b f0", frame_bits(8'hC1, 1'b1), 11'h0, 1'b0);
        tick();
        check("b2b f1 empty", 32'(empty), 32'd0);
        check_frame("b2b f1", frame_bits(8'h22, 1'b0), 11'h0, 1'b0);
        tick();
        check("b2b f2 empty", 32'(empty), 32'd0);
        check_frame("b2b f2", frame_bits(8'h93, 1'b0), 11'h0, 1'b0);
        tick();
        check("b2b f3 empty", 32'(empty), 32'd1);
        check_frame("b2b f3", frame_bits(8'h4E, 1'b0), 11'h0, 1'b0);
        tick();
        check("b2b busy_end", 32'(busy), 32'd0);
        bad = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("b2b no_extra_frame", 32'(bad), 32'd0);

        // Async reset mid-frame with a byte still queued
        datain = 8'h5A;
        wrsig  = 1'b1;
        tick();
        datain = 8'h3F;
        tick();
        wrsig = 1'b0;
        tick();
        check("rstmid tx_low", 32'(tx), 32'd0);
        for (int c = 0; c < 60; c++) tick();
        check("rstmid queued", 32'(empty), 32'd0);
        check("rstmid busy_before", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rstmid tx_async", 32'(tx), 32'd1);
        check("rstmid busy_async", 32'(busy), 32'd0);
        check("rstmid empty_async", 32'(empty), 32'd1);
        check("rstmid full_async", 32'(full), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rstmid empty_release", 32'(empty), 32'd1);
        bad = 0;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0 || txdone !== 1'b0) bad++;
        end
        check("rstmid no_resume", 32'(bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
